usb_hid_kbd_event_fifo: RTL and testbench

//  Sits downstream of the USB HID host's keyboard report outputs, in the Wishbone clock domain.

---
 rtl/usb_hid_kbd_event_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_usb_hid_kbd_event_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/usb_hid_kbd_event_fifo.sv
// Keyboard report differ: turns successive HID boot reports into make/break usage events in a FWFT FIFO.
// Define KBD_EVT_MODIFIER_EN to also scan the eight modifier bits (usages 0xE0-0xE7).
module usb_hid_kbd_event_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  wb_clk,
   input  logic                  sys_rst_n,
   input  logic                  rpt_stb,
   input  logic [7:0]            rpt_modifiers,
   input  logic [7:0]            rpt_key1,
   input  logic [7:0]            rpt_key2,
   input  logic [7:0]            rpt_key3,
   input  logic [7:0]            rpt_key4,
   input  logic                  conn_clr,
   input  logic                  evt_pop,
   output logic                  evt_valid,
   output logic [8:0]            evt_data,
   output logic [DEPTH_LOG2:0]   evt_count,
   output logic                  evt_ovf,
   input  logic                  ovf_clr
);
`ifdef KBD_EVT_MODIFIER_EN
   localparam int NSLOT = 12;
`else
   localparam int NSLOT = 4;
`endif
   localparam int IDX_W = $clog2(NSLOT);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_MAK, S_COMMIT} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [7:0]             cur_q  [NSLOT], cur_d  [NSLOT];
   logic [7:0]             prev_q [NSLOT], prev_d [NSLOT];
   logic [7:0]             pend_q [NSLOT], pend_d [NSLOT];
   logic                   pend_full_q, pend_full_d;
   logic [7:0]             rpt_slots [NSLOT];
   logic                   rollover;

   always_comb begin
      rpt_slots[0] = rpt_key1;
      rpt_slots[1] = rpt_key2;
      rpt_slots[2] = rpt_key3;
      rpt_slots[3] = rpt_key4;
`ifdef KBD_EVT_MODIFIER_EN
      for (int b = 0; b < 8; b++)
         rpt_slots[4+b] = rpt_modifiers[b] ? (8'hE0 + 8'(b)) : 8'h00;
`endif
   end
`ifndef KBD_EVT_MODIFIER_EN
   logic unused_mods;
   assign unused_mods = ^rpt_modifiers;
`endif

   // 0x01 in any key slot is the keyboard's phantom/rollover report
   assign rollover = (rpt_key1 == 8'h01) || (rpt_key2 == 8'h01) ||
                     (rpt_key3 == 8'h01) || (rpt_key4 == 8'h01);

   // Scan: BRK walks prev looking for usages gone from cur, MAK the reverse
   logic [7:0] scan_u, self_u, oth_u;
   logic       scan_hit, scan_dup, push;
   logic [8:0] push_data;

   always_comb begin
      scan_u   = (state_q == S_MAK) ? cur_q[idx_q] : prev_q[idx_q];
      scan_hit = 1'b0;
      scan_dup = 1'b0;
      self_u   = 8'h00;
      oth_u    = 8'h00;
      for (int i = 0; i < NSLOT; i++) begin
         self_u = (state_q == S_MAK) ? cur_q[i]  : prev_q[i];
         oth_u  = (state_q == S_MAK) ? prev_q[i] : cur_q[i];
         if (oth_u == scan_u) scan_hit = 1'b1;
         if ((IDX_W'(i) < idx_q) && (self_u == scan_u)) scan_dup = 1'b1;
      end
      push      = ((state_q == S_BRK) || (state_q == S_MAK)) &&
                  (scan_u != 8'h00) && !scan_hit && !scan_dup;
      push_data = {state_q == S_BRK, scan_u};
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cur_d       = cur_q;
      prev_d      = prev_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      case (state_q)
         S_IDLE: if (pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
            idx_d       = '0;
            state_d     = S_BRK;
         end
         S_BRK: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NSLOT-1)) begin
               idx_d   = '0;
               state_d = S_MAK;
            end
         end
         S_MAK: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NSLOT-1)) begin
               idx_d   = '0;
               state_d = S_COMMIT;
            end
         end
         default: begin
            prev_d  = cur_q;
            state_d = S_IDLE;
         end
      endcase
      // Newest report always wins the pending slot, even over a same-cycle load
      if (rpt_stb && !rollover) begin
         pend_d      = rpt_slots;
         pend_full_d = 1'b1;
      end
      if (conn_clr) begin
         state_d     = S_IDLE;
         idx_d       = '0;
         pend_full_d = 1'b0;
         for (int i = 0; i < NSLOT; i++) begin
            prev_d[i] = 8'h00;
            pend_d[i] = 8'h00;
         end
      end
   end

   always_ff @(posedge wb_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         pend_full_q <= 1'b0;
         for (int i = 0; i < NSLOT; i++) begin
            cur_q[i]  <= 8'h00;
            prev_q[i] <= 8'h00;
            pend_q[i] <= 8'h00;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pend_full_q <= pend_full_d;
         cur_q       <= cur_d;
         prev_q      <= prev_d;
         pend_q      <= pend_d;
      end
   end

   // FIFO
   logic [8:0]            evt_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  full, pop_ok, push_ok;

   assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign pop_ok  = evt_pop && (count_q != '0);
   assign push_ok = push && !conn_clr && (!full || pop_ok);

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
      if (ovf_clr) ovf_d = 1'b0;
      if (push && !conn_clr && full && !pop_ok) ovf_d = 1'b1;
      if (conn_clr) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge wb_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (push_ok) evt_mem[wr_q] <= push_data;
   end

   assign evt_valid = (count_q != '0);
   assign evt_data  = evt_valid ? evt_mem[rd_q] : 9'h000;
   assign evt_count = count_q;
   assign evt_ovf   = ovf_q;
endmodule

// File: tb/tb_usb_hid_kbd_event_fifo.sv
// Scoreboard bench for usb_hid_kbd_event_fifo (4-entry FIFO); expected events queued at stimulus,
// checked by an auto-popping monitor.
module tb_usb_hid_kbd_event_fifo;
   localparam int DL = 2;
`ifdef KBD_EVT_MODIFIER_EN
   localparam int NS = 12;
`else
   localparam int NS = 4;
`endif

   logic          wb_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          rpt_stb = 1'b0;
   logic [7:0]    rpt_modifiers = '0, rpt_key1 = '0, rpt_key2 = '0, rpt_key3 = '0, rpt_key4 = '0;
   logic          conn_clr = 1'b0, ovf_clr = 1'b0;
   logic          evt_pop, evt_valid, evt_ovf;
   logic [8:0]    evt_data;
   logic [DL:0]   evt_count;
   logic          tb_pop = 1'b0, mon_pop = 1'b0, auto_pop = 1'b0;
   logic [8:0]    exp_q [$];
   int            n_cmp = 0, n_err = 0;

   assign evt_pop = tb_pop | mon_pop;

   usb_hid_kbd_event_fifo #(.DEPTH_LOG2(DL)) dut (
      .wb_clk(wb_clk), .sys_rst_n(sys_rst_n), .rpt_stb(rpt_stb),
      .rpt_modifiers(rpt_modifiers), .rpt_key1(rpt_key1), .rpt_key2(rpt_key2),
      .rpt_key3(rpt_key3), .rpt_key4(rpt_key4), .conn_clr(conn_clr),
      .evt_pop(evt_pop), .evt_valid(evt_valid), .evt_data(evt_data),
      .evt_count(evt_count), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr));

   always #5 wb_clk = ~wb_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops and compares every presented event while auto_pop is on
   always @(negedge wb_clk) begin
      mon_pop = 1'b0;
      if (auto_pop && evt_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected event: got %0h want none", evt_data);
         end else begin
            chk("event", 32'(evt_data), 32'(exp_q.pop_front()));
         end
         mon_pop = 1'b1;
      end
   end

   task automatic send(input logic [7:0] m, a, b, c, d);
      rpt_modifiers = m; rpt_key1 = a; rpt_key2 = b; rpt_key3 = c; rpt_key4 = d;
      rpt_stb = 1'b1;
      @(posedge wb_clk); #1 rpt_stb = 1'b0;
   endtask

   task automatic idle_wait();
      repeat (2*NS+6) @(posedge wb_clk);
      #1;
   endtask

   task automatic pulse_clr(input bit ovf);
      if (ovf) ovf_clr = 1'b1; else conn_clr = 1'b1;
      @(posedge wb_clk); #1 ovf_clr = 1'b0; conn_clr = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while ((exp_q.size() != 0 || evt_valid) && t < 200) begin
         @(posedge wb_clk);
         t++;
      end
      #1 chk({nm, " left"}, 32'(exp_q.size()), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst valid", 32'(evt_valid), 0);
      chk("rst data",  32'(evt_data), 0);
      chk("rst count", 32'(evt_count), 0);
      chk("rst ovf",   32'(evt_ovf), 0);
      @(posedge wb_clk); #1 sys_rst_n = 1'b1;
      @(posedge wb_clk); #1;

      // 1: press
      exp_q.push_back(9'h004);
`ifdef KBD_EVT_MODIFIER_EN
      exp_q.push_back(9'h0E1);
      send(8'h02, 8'h04, 0, 0, 0); idle_wait();
      chk("t1 count", 32'(evt_count), 2);
`else
      send(8'h02, 8'h04, 0, 0, 0); idle_wait();
      chk("t1 count", 32'(evt_count), 1);
`endif
      auto_pop = 1'b1;
      drain("t1");

      // 2: break before make
      exp_q.push_back(9'h104); exp_q.push_back(9'h005);
      send(8'h02, 8'h05, 0, 0, 0); idle_wait(); drain("t2");

      // 3: rollover discarded, prev kept; duplicates give one make
      send(8'h02, 8'h01, 8'h01, 8'h01, 8'h01); idle_wait();
      chk("t3 rollover count", 32'(evt_count), 0);
      send(8'h02, 8'h05, 0, 0, 0); idle_wait(); drain("t3 prev kept");
      exp_q.push_back(9'h105); exp_q.push_back(9'h006);
      send(8'h02, 8'h06, 8'h06, 0, 0); idle_wait(); drain("t3 dup");

      // 4: overflow on a 4-deep FIFO
      pulse_clr(1'b0);
      auto_pop = 1'b0;
      send(0, 8'h04, 8'h05, 8'h06, 8'h07); idle_wait();
      chk("t4 fill count", 32'(evt_count), 4);
      chk("t4 fill ovf", 32'(evt_ovf), 0);
      send(0, 8'h04, 8'h05, 8'h06, 8'h08); idle_wait();
      chk("t4 count", 32'(evt_count), 4);
      chk("t4 ovf", 32'(evt_ovf), 1);
      chk("t4 head", 32'(evt_data), 32'h004);
      pulse_clr(1'b1);
      chk("t4 ovf clr", 32'(evt_ovf), 0);
      send(0, 8'h04, 8'h05, 8'h06, 8'h07);
      repeat (4) @(posedge wb_clk);
      #1 tb_pop = 1'b1;
      @(posedge wb_clk); #1 tb_pop = 1'b0;
      chk("t4 pop+push full", 32'(evt_count), 4);
      idle_wait();
      chk("t4 count2", 32'(evt_count), 4);
      chk("t4 ovf2", 32'(evt_ovf), 1);
      chk("t4 head2", 32'(evt_data), 32'h005);
      exp_q.push_back(9'h005); exp_q.push_back(9'h006);
      exp_q.push_back(9'h007); exp_q.push_back(9'h108);
      auto_pop = 1'b1;
      drain("t4");
      pulse_clr(1'b1);
      chk("t4 ovf clr2", 32'(evt_ovf), 0);

      // 5: back-to-back reports, middle one overwritten
      pulse_clr(1'b0);
      exp_q.push_back(9'h004); exp_q.push_back(9'h104); exp_q.push_back(9'h006);
      send(0, 8'h04, 0, 0, 0); @(posedge wb_clk); #1;
      send(0, 8'h05, 0, 0, 0); @(posedge wb_clk); #1;
      send(0, 8'h06, 0, 0, 0);
      idle_wait(); idle_wait(); drain("t5");

      // 6: conn_clr mid-scan with 3 events queued
      pulse_clr(1'b0);
      auto_pop = 1'b0;
      send(0, 8'h04, 8'h05, 8'h06, 0); idle_wait();
      chk("t6 queued", 32'(evt_count), 3);
      send(0, 8'h04, 8'h05, 8'h06, 8'h08);
      repeat (3) @(posedge wb_clk);
      #1 conn_clr = 1'b1;
      @(posedge wb_clk); #1 conn_clr = 1'b0;
      chk("t6 valid", 32'(evt_valid), 0);
      chk("t6 count", 32'(evt_count), 0);
      chk("t6 ovf kept", 32'(evt_ovf), 0);
      auto_pop = 1'b1;
      exp_q.push_back(9'h004);
      send(0, 8'h04, 0, 0, 0); idle_wait(); drain("t6 after");

      // async reset mid-scan
      auto_pop = 1'b0;
      send(0, 8'h05, 0, 0, 0);
      repeat (2) @(posedge wb_clk);
      #1 chk("ar pre count", 32'(evt_count), 1);
      chk("ar pre data", 32'(evt_data), 32'h104);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("ar valid", 32'(evt_valid), 0);
      chk("ar data",  32'(evt_data), 0);
      chk("ar count", 32'(evt_count), 0);
      chk("ar ovf",   32'(evt_ovf), 0);
      @(posedge wb_clk); #1 sys_rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
